// File: rtl/mmio_ctrl_pkg.sv
// Shared constants, types and address decode for the MMIO controller.
// Used by mmio_ctrl and mmio_fifo; MMIO_CYCLE_COUNTER_EN is consumed in mmio_ctrl.
package mmio_ctrl_pkg;

    localparam int unsigned FIFO_DEPTH_DEFAULT = 8;

    // Region select on cpu_a[17:16] and the fixed I/O registers inside it.
    localparam logic [1:0]  IO_REGION = 2'b11;
    localparam logic [17:0] ADDR_UART = 18'h30000;
    localparam logic [17:0] ADDR_EXIT = 18'h30004;
    localparam logic [17:0] ADDR_CNT1 = 18'h30005;
    localparam logic [17:0] ADDR_CNT2 = 18'h30006;
    localparam logic [17:0] ADDR_CNT3 = 18'h30007;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_RAM  = 2'd1,
        SEL_IO   = 2'd2
    } rd_sel_e;

    typedef struct packed {
        logic io;
        logic uart;
        logic exit;
        logic cnt1;
        logic cnt2;
        logic cnt3;
    } addr_dec_t;

    function automatic addr_dec_t decode_addr(input logic [17:0] a);
        addr_dec_t d;
        d.io   = (a[17:16] == IO_REGION);
        d.uart = (a == ADDR_UART);
        d.exit = (a == ADDR_EXIT);
        d.cnt1 = (a == ADDR_CNT1);
        d.cnt2 = (a == ADDR_CNT2);
        d.cnt3 = (a == ADDR_CNT3);
        return d;
    endfunction

endpackage

// File: rtl/mmio_fifo.sv
// Synchronous FIFO with extra-MSB pointers; push and pop may both happen
// in the same cycle, including when full.
module mmio_fifo
    import mmio_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign dout  = mem_q[rd_ptr_q[AW-1:0]];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mmio_ctrl.sv
// CPU memory-mapped I/O controller: RAM pass-through, UART RX/TX FIFOs,
// exit flag and an optional cycle counter enabled by MMIO_CYCLE_COUNTER_EN.
module mmio_ctrl
    import mmio_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic        cpu_rdy,
    output logic [16:0] ram_a,
    output logic [7:0]  ram_dout,
    output logic        ram_wr,
    input  logic [7:0]  ram_din,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        program_finish
);

    addr_dec_t dec;
    logic      unused_a_hi;
    logic      wr_nz;
    logic      stall;

    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0] rx_dout;
    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0] tx_din, tx_dout;

    rd_sel_e    sel_q, sel_d;
    logic [7:0] io_data_q, io_data_d;
    logic [7:0] io_rd_byte;
    logic       finish_q, finish_d;

    assign dec         = decode_addr(cpu_a[17:0]);
    assign unused_a_hi = ^cpu_a[31:18];
    assign wr_nz       = (cpu_dout != 8'h00);

    // Stall is forced off during reset so a pending access is released.
    always_comb begin
        stall = 1'b0;
        if (!rst_in) begin
            if (!cpu_wr && dec.uart && rx_empty) stall = 1'b1;
            if (cpu_wr && tx_full && (dec.exit || (dec.uart && wr_nz))) stall = 1'b1;
        end
    end

    assign cpu_rdy  = rdy_in & ~stall;
    assign ram_a    = cpu_a[16:0];
    assign ram_dout = cpu_dout;
    assign ram_wr   = cpu_wr & cpu_rdy & ~dec.io;

    // Stream handshakes are qualified with rdy_in so nothing moves while it is low.
    assign rx_ready = rdy_in & ~rx_full;
    assign rx_push  = rx_valid & rx_ready;
    assign rx_pop   = cpu_rdy & ~cpu_wr & dec.uart;

    assign tx_push  = cpu_rdy & cpu_wr & (dec.exit | (dec.uart & wr_nz));
    assign tx_din   = dec.exit ? 8'h00 : cpu_dout;
    assign tx_valid = rdy_in & ~tx_empty;
    assign tx_data  = tx_dout;
    assign tx_pop   = tx_valid & tx_ready;

    mmio_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_rx_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (rx_push),
        .din    (rx_data),
        .pop    (rx_pop),
        .dout   (rx_dout),
        .full   (rx_full),
        .empty  (rx_empty)
    );

    mmio_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (tx_push),
        .din    (tx_din),
        .pop    (tx_pop),
        .dout   (tx_dout),
        .full   (tx_full),
        .empty  (tx_empty)
    );

`ifdef MMIO_CYCLE_COUNTER_EN
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] snap_q, snap_d;

    // Reading byte 0 freezes the whole count so the upper bytes read coherently.
    always_comb begin
        cnt_d  = cnt_q;
        snap_d = snap_q;
        if (rdy_in) cnt_d = cnt_q + 32'd1;
        if (cpu_rdy && !cpu_wr && dec.exit) snap_d = cnt_q;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cnt_q  <= '0;
            snap_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            snap_q <= snap_d;
        end
    end

    always_comb begin
        io_rd_byte = 8'h00;
        if (dec.uart)      io_rd_byte = rx_dout;
        else if (dec.exit) io_rd_byte = cnt_q[7:0];
        else if (dec.cnt1) io_rd_byte = snap_q[15:8];
        else if (dec.cnt2) io_rd_byte = snap_q[23:16];
        else if (dec.cnt3) io_rd_byte = snap_q[31:24];
    end
`else
    logic unused_cnt;
    assign unused_cnt = dec.cnt1 | dec.cnt2 | dec.cnt3;

    always_comb begin
        io_rd_byte = 8'h00;
        if (dec.uart) io_rd_byte = rx_dout;
    end
`endif

    // I/O read data is captured at acceptance; RAM data arrives registered by the RAM.
    always_comb begin
        sel_d     = sel_q;
        io_data_d = io_data_q;
        finish_d  = finish_q;
        if (cpu_rdy) begin
            if (cpu_wr) begin
                sel_d = SEL_NONE;
                if (dec.exit) finish_d = 1'b1;
            end else if (dec.io) begin
                sel_d     = SEL_IO;
                io_data_d = io_rd_byte;
            end else begin
                sel_d = SEL_RAM;
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sel_q     <= SEL_NONE;
            io_data_q <= 8'h00;
            finish_q  <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            io_data_q <= io_data_d;
            finish_q  <= finish_d;
        end
    end

    always_comb begin
        case (sel_q)
            SEL_IO:  cpu_din = io_data_q;
            SEL_RAM: cpu_din = ram_din;
            default: cpu_din = 8'h00;
        endcase
    end

    assign program_finish = finish_q;

endmodule

// File: tb/tb_mmio_ctrl.sv
// Self-checking bench for mmio_ctrl: vector table for decode, scoreboard queues
// for read data and the UART transmit stream, hand-written multi-cycle sequences.
module tb_mmio_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        cpu_rdy;
    logic [16:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_wr;
    logic [7:0]  ram_din;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        program_finish;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_rd_q[$];
    logic [7:0] exp_tx_q[$];

    typedef struct {
        logic [31:0] a;
        logic        wr;
        logic [7:0]  dout;
        logic [16:0] exp_ram_a;
        logic        exp_ram_wr;
        logic [7:0]  exp_din;
    } vec_t;

    localparam int NV = 11;
    vec_t vecs[NV];

    mmio_ctrl dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .cpu_a          (cpu_a),
        .cpu_dout       (cpu_dout),
        .cpu_wr         (cpu_wr),
        .cpu_din        (cpu_din),
        .cpu_rdy        (cpu_rdy),
        .ram_a          (ram_a),
        .ram_dout       (ram_dout),
        .ram_wr         (ram_wr),
        .ram_din        (ram_din),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .program_finish (program_finish)
    );

    // Clock and RAM model: read data is a known function of the address, one cycle late.
    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) ram_din <= ram_a[7:0] ^ 8'hA5;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic cmp_rd(input string name);
        if (exp_rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no expected read data queued, got %h", name, cpu_din);
        end else begin
            check(name, {24'h0, cpu_din}, {24'h0, exp_rd_q.pop_front()});
        end
    endtask

    task automatic idle();
        cpu_a    = 32'h0;
        cpu_wr   = 1'b0;
        cpu_dout = 8'h00;
    endtask

    task automatic wait_rdy(input string name);
        int n;
        n = 0;
        while (cpu_rdy !== 1'b1 && n < 40) begin
            @(negedge clk_in);
            #1;
            n++;
        end
        checks++;
        if (cpu_rdy !== 1'b1) begin
            errors++;
            $display("FAIL %s: cpu_rdy timeout got %b required 1", name, cpu_rdy);
        end
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] exp, input string name);
        @(negedge clk_in);
        cpu_a  = addr;
        cpu_wr = 1'b0;
        #1;
        wait_rdy(name);
        exp_rd_q.push_back(exp);
        @(negedge clk_in);
        cmp_rd(name);
        idle();
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] data, input string name);
        @(negedge clk_in);
        cpu_a    = addr;
        cpu_wr   = 1'b1;
        cpu_dout = data;
        #1;
        wait_rdy(name);
        @(negedge clk_in);
        idle();
    endtask

    // Transmit scoreboard: every byte taken by the sink must match the queue head.
    always @(negedge clk_in) begin
        #2;
        if (!rst_in && tx_valid && tx_ready) begin
            if (exp_tx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected: got byte %h required none", tx_data);
            end else begin
                check("tx_data", {24'h0, tx_data}, {24'h0, exp_tx_q.pop_front()});
            end
        end
    end

    initial begin
        logic [7:0] rxb[8];
        logic [7:0] b;
        logic       pend;

        vecs[0]  = '{32'h0000_0000, 1'b0, 8'h12, 17'h00000, 1'b0, 8'hA5};
        vecs[1]  = '{32'h0001_ABCD, 1'b0, 8'h34, 17'h1ABCD, 1'b0, 8'h68};
        vecs[2]  = '{32'h0002_FFFF, 1'b0, 8'h56, 17'h0FFFF, 1'b0, 8'h5A};
        vecs[3]  = '{32'hFFFC_1234, 1'b0, 8'h78, 17'h01234, 1'b0, 8'h91};
        vecs[4]  = '{32'h0001_0055, 1'b1, 8'h3C, 17'h10055, 1'b1, 8'h00};
        vecs[5]  = '{32'h0003_0008, 1'b1, 8'h99, 17'h10008, 1'b0, 8'h00};
        vecs[6]  = '{32'h0003_0008, 1'b0, 8'h00, 17'h10008, 1'b0, 8'h00};
        vecs[7]  = '{32'h0003_FFFF, 1'b0, 8'h00, 17'h1FFFF, 1'b0, 8'h00};
        vecs[8]  = '{32'h0003_0000, 1'b1, 8'h00, 17'h10000, 1'b0, 8'h00};
        vecs[9]  = '{32'h0003_0001, 1'b0, 8'h00, 17'h10001, 1'b0, 8'h00};
        vecs[10] = '{32'h0003_0003, 1'b0, 8'h00, 17'h10003, 1'b0, 8'h00};

        rst_in   = 1'b1;
        rdy_in   = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b1;
        idle();

        // Reset state
        repeat (3) @(negedge clk_in);
        #1;
        check("rst_cpu_din", {24'h0, cpu_din}, 32'h0);
        check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
        check("rst_finish", {31'h0, program_finish}, 32'h0);
        check("rst_cpu_rdy", {31'h0, cpu_rdy}, 32'h1);
        @(negedge clk_in);
        rst_in = 1'b0;

        // Decode table: RAM pass-through, region select, ignored I/O addresses
        pend = 1'b0;
        for (int i = 0; i < NV; i++) begin
            @(negedge clk_in);
            if (pend) cmp_rd("tbl_din");
            cpu_a    = vecs[i].a;
            cpu_wr   = vecs[i].wr;
            cpu_dout = vecs[i].dout;
            #1;
            check("tbl_ram_a", {15'h0, ram_a}, {15'h0, vecs[i].exp_ram_a});
            check("tbl_ram_wr", {31'h0, ram_wr}, {31'h0, vecs[i].exp_ram_wr});
            check("tbl_ram_dout", {24'h0, ram_dout}, {24'h0, vecs[i].dout});
            check("tbl_cpu_rdy", {31'h0, cpu_rdy}, 32'h1);
            pend = ~vecs[i].wr;
            if (pend) exp_rd_q.push_back(vecs[i].exp_din);
        end
        @(negedge clk_in);
        if (pend) cmp_rd("tbl_din");
        idle();
        #1;
        check("tbl_zero_write_no_tx", {31'h0, tx_valid}, 32'h0);

        // TX: non-zero byte appears one cycle later, zero byte is dropped
        exp_tx_q.push_back(8'h41);
        do_write(32'h0003_0000, 8'h41, "tx_wr_41");
        #1;
        check("tx_valid_after_wr", {31'h0, tx_valid}, 32'h1);
        check("tx_data_after_wr", {24'h0, tx_data}, 32'h41);
        do_write(32'h0003_0000, 8'h00, "tx_wr_00");
        #1;
        check("tx_zero_ignored", {31'h0, tx_valid}, 32'h0);

        // RX: read stalls while empty, releases when a byte arrives
        @(negedge clk_in);
        cpu_a  = 32'h0003_0000;
        cpu_wr = 1'b0;
        #1;
        check("rx_empty_stall", {31'h0, cpu_rdy}, 32'h0);
        repeat (2) @(negedge clk_in);
        #1;
        check("rx_empty_stall_hold", {31'h0, cpu_rdy}, 32'h0);
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        @(negedge clk_in);
        rx_valid = 1'b0;
        #1;
        check("rx_rdy_rise", {31'h0, cpu_rdy}, 32'h1);
        exp_rd_q.push_back(8'h5A);
        @(negedge clk_in);
        cmp_rd("rx_din_5a");
        idle();

        // RX: fill to depth, backpressure, drain in order
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_in);
            rxb[i]   = 8'($urandom_range(0, 255));
            rx_valid = 1'b1;
            rx_data  = rxb[i];
        end
        @(negedge clk_in);
        rx_valid = 1'b0;
        #1;
        check("rx_full_ready", {31'h0, rx_ready}, 32'h0);
        for (int i = 0; i < 8; i++) do_read(32'h0003_0000, rxb[i], "rx_drain");
        #1;
        check("rx_ready_after_drain", {31'h0, rx_ready}, 32'h1);

        // TX: fill with sink stalled, 9th write stalls, then all 9 leave in order
        @(negedge clk_in);
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b = 8'($urandom_range(1, 255));
            exp_tx_q.push_back(b);
            do_write(32'h0003_0000, b, "tx_fill");
        end
        @(negedge clk_in);
        b        = 8'($urandom_range(1, 255));
        cpu_a    = 32'h0003_0000;
        cpu_wr   = 1'b1;
        cpu_dout = b;
        exp_tx_q.push_back(b);
        #1;
        check("tx_full_stall", {31'h0, cpu_rdy}, 32'h0);
        check("tx_full_no_ramwr", {31'h0, ram_wr}, 32'h0);
        @(negedge clk_in);
        tx_ready = 1'b1;
        #1;
        wait_rdy("tx_stall_release");
        @(negedge clk_in);
        idle();
        repeat (12) @(negedge clk_in);
        check("tx_drain_all", exp_tx_q.size(), 32'h0);

`ifdef MMIO_CYCLE_COUNTER_EN
        // Counter wrap and coherent snapshot bytes
        @(negedge clk_in);
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_q;
        repeat (2) @(negedge clk_in);
        do_read(32'h0003_0004, 8'h01, "cnt_byte0");
        do_read(32'h0003_0005, 8'h00, "cnt_byte1");
        do_read(32'h0003_0006, 8'h00, "cnt_byte2");
        do_read(32'h0003_0007, 8'h00, "cnt_byte3");
`else
        do_read(32'h0003_0004, 8'h00, "nocnt_byte0");
        do_read(32'h0003_0005, 8'h00, "nocnt_byte1");
        do_read(32'h0003_0006, 8'h00, "nocnt_byte2");
        do_read(32'h0003_0007, 8'h00, "nocnt_byte3");
`endif

        // rdy_in low: pending UART write and incoming RX byte must have no effect
        @(negedge clk_in);
        rdy_in   = 1'b0;
        cpu_a    = 32'h0003_0000;
        cpu_wr   = 1'b1;
        cpu_dout = 8'h77;
        rx_valid = 1'b1;
        rx_data  = 8'hC3;
        #1;
        check("hold_cpu_rdy", {31'h0, cpu_rdy}, 32'h0);
        check("hold_ram_wr", {31'h0, ram_wr}, 32'h0);
        repeat (4) @(negedge clk_in);
        idle();
        rx_valid = 1'b0;
        rdy_in   = 1'b1;
        #1;
        check("hold_tx_empty", {31'h0, tx_valid}, 32'h0);
        @(negedge clk_in);
        cpu_a  = 32'h0003_0000;
        cpu_wr = 1'b0;
        #1;
        check("hold_rx_empty", {31'h0, cpu_rdy}, 32'h0);
        @(negedge clk_in);
        idle();

        // Exit write, sticky flag, then reset mid-operation
        exp_tx_q.push_back(8'h00);
        do_write(32'h0003_0004, 8'h55, "exit_wr");
        #1;
        check("finish_set", {31'h0, program_finish}, 32'h1);
        repeat (4) @(negedge clk_in);
        check("exit_tx_byte", exp_tx_q.size(), 32'h0);
        check("finish_sticky", {31'h0, program_finish}, 32'h1);
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) do_write(32'h0003_0000, 8'(8'h11 + i), "pre_rst_fill");
        @(negedge clk_in);
        rx_valid = 1'b1;
        rx_data  = 8'hE7;
        @(negedge clk_in);
        rx_valid = 1'b0;
        cpu_a    = 32'h0003_0000;
        cpu_wr   = 1'b1;
        cpu_dout = 8'h22;
        #1;
        check("pend_stall", {31'h0, cpu_rdy}, 32'h0);
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        check("mid_rst_cpu_rdy", {31'h0, cpu_rdy}, 32'h1);
        check("mid_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        check("mid_rst_rx_ready", {31'h0, rx_ready}, 32'h1);
        check("mid_rst_finish", {31'h0, program_finish}, 32'h0);
        check("mid_rst_cpu_din", {24'h0, cpu_din}, 32'h0);
        @(negedge clk_in);
        idle();
        rst_in   = 1'b0;
        tx_ready = 1'b1;
        #1;
        check("post_rst_tx_empty", {31'h0, tx_valid}, 32'h0);
        @(negedge clk_in);
        cpu_a  = 32'h0003_0000;
        cpu_wr = 1'b0;
        #1;
        check("post_rst_rx_empty", {31'h0, cpu_rdy}, 32'h0);
        @(negedge clk_in);
        idle();
        repeat (3) @(negedge clk_in);
        check("final_tx_queue", exp_tx_q.size(), 32'h0);
        check("final_rd_queue", exp_rd_q.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mmio_ctrl.md
MMIO_CTRL -- requirements
Module: mmio_ctrl

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, gives the entries in each of the RX and TX FIFOs; it SHALL be a power of two and at least 2.
REQ-002 clk_in  input  1  system clock; the block SHALL use this one clock only.
REQ-003 rst_in  input  1  reset; it SHALL be asynchronous and active-high.
REQ-004 rdy_in  input  1  external ready; when low, the block SHALL have no side effects and SHALL hold all state.
REQ-005 cpu_a  input  32  CPU address bus (mem_a); only bits 17:0 SHALL be decoded.
REQ-006 cpu_dout  input  8  CPU write byte.
REQ-007 cpu_wr  input  1  1 = write, 0 = read.
REQ-008 cpu_din  output  8  read byte returned to the CPU.
REQ-009 cpu_rdy  output  1  gated ready to the CPU.
REQ-010 ram_a  output  17  RAM address.
REQ-011 ram_dout  output  8  RAM write data.
REQ-012 ram_wr  output  1  RAM write enable.
REQ-013 ram_din  input  8  RAM read data, registered inside the RAM.
REQ-014 rx_data  input  8  and rx_valid  input  1  UART receive stream.
REQ-015 rx_ready  output  1  UART receive backpressure.
REQ-016 tx_data  output  8  and tx_valid  output  1  UART transmit stream.
REQ-017 tx_ready  input  1  UART transmit backpressure.
REQ-018 program_finish  output  1  sticky flag, set when the program stops.

Function
REQ-019 An access is an I/O access when cpu_a[17:16]==2'b11; every other access SHALL be a RAM access.
- RAM accesses: ram_a = cpu_a[16:0], ram_dout = cpu_dout.
- ram_wr = cpu_wr & cpu_rdy & RAM access.
REQ-020 Read latency SHALL be one cycle.
- A read accepted in cycle t returns data on cpu_din in cycle t+1.
- The select between RAM and I/O data SHALL be registered at t.
REQ-021 cpu_rdy = rdy_in & ~stall, where stall is combinational and asserted in either case:
- read of 0x30000 while the RX FIFO is empty;
- write to 0x30000 or 0x30004 while the TX FIFO is full.
REQ-022 Read of 0x30000 with cpu_rdy high SHALL pop the RX FIFO; the popped byte appears on cpu_din at t+1.
REQ-023 Write to 0x30000:
- non-zero byte with cpu_rdy high SHALL push cpu_dout into the TX FIFO;
- byte 0x00 SHALL be ignored: no push, and no stall even if the TX FIFO is full.
REQ-024 Write to 0x30004 with cpu_rdy high SHALL push 0x00 into the TX FIFO and set program_finish.
- program_finish SHALL stay set until reset.
REQ-025 Cycle counter: 32-bit, increments on every clk_in edge while rdy_in is high, wraps from 0xFFFFFFFF to 0.
REQ-026 Read of 0x30004 SHALL return counter[7:0] and latch the full counter into a snapshot in the same cycle.
- Reads of 0x30005, 0x30006 and 0x30007 SHALL return snapshot bytes 1, 2 and 3.
REQ-027 Reads of other I/O addresses SHALL return 0x00; writes to them SHALL be ignored.
REQ-028 RX FIFO behaviour:
- rx_ready = ~rx_full;
- a push occurs when rx_valid & rx_ready;
- a push and a pop in the same cycle when full SHALL both take effect, leaving count unchanged;
- while full, rx_ready is low and the sender SHALL hold rx_valid and rx_data until rx_ready rises.
REQ-029 TX FIFO behaviour:
- tx_valid = ~tx_empty and tx_data = head entry;
- a pop occurs when tx_valid & tx_ready;
- a push and a pop in the same cycle when full SHALL both take effect.
REQ-030 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide; the MSB distinguishes full from empty across wrap-around.

Reset
REQ-031 Reset SHALL clear:
- both FIFOs (empty);
- the counter and the snapshot to 0;
- program_finish to 0;
- the registered read select, so cpu_din = 0x00.
REQ-032 Reset mid-operation SHALL abandon any pending stall, and SHALL discard all FIFO contents.
- cpu_rdy then equals rdy_in.
- tx_valid = 0.
- rx_ready = 1.

Configuration
REQ-033 With macro MMIO_CYCLE_COUNTER_EN defined, the counter and snapshot SHALL be built as specified in REQ-025 and REQ-026.
REQ-034 Without MMIO_CYCLE_COUNTER_EN, the counter and snapshot SHALL be absent, and reads of 0x30004 to 0x30007 SHALL return 0x00.

Structure
REQ-035 The I/O address constants (0x30000, 0x30004, I/O region select 2'b11) SHALL live in the shared defines package.
- The FIFO_DEPTH default SHALL live there too.
REQ-036 One sub-module, mmio_fifo, SHALL be instantiated twice, once for RX and once for TX.
- Interface: clk_in, rst_in, push, din, pop, dout, full, empty.

Verification
REQ-037 Write 0x41 to 0x30000 with tx_ready=1 -> tx_valid=1, tx_data=0x41 one cycle later; write 0x00 -> no tx_valid.
REQ-038 Read 0x30000 with RX empty -> cpu_rdy=0; drive rx byte 0x5A -> cpu_rdy rises and cpu_din=0x5A on the next cycle.
REQ-039 Hold tx_ready=0 and write 9 non-zero bytes (depth 8) -> cpu_rdy=0 on the 9th write; release tx_ready -> all 9 bytes transmitted in order.
REQ-040 Preload counter 0xFFFFFFFE, run 3 cycles, read 0x30004 to 0x30007 -> bytes of 0x00000001, unchanged by counting between reads.
REQ-041 Write to 0x30004 -> program_finish=1 and tx byte 0x00; assert rst_in -> program_finish=0 and FIFOs empty.
REQ-042 rdy_in=0 with a pending write to 0x30000 and rx_valid=1 -> no FIFO or counter change, cpu_rdy=0.
